// File: rtl/button_pkg.sv
// Shared constants and state type for the push-button conditioning path.
package button_pkg;

    localparam int unsigned CLK_HZ                = 25_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF   = 250_000;      // 10 ms at CLK_HZ
    localparam int unsigned LONG_PRESS_CYCLES_DEF = 25_000_000;   // 1 s at CLK_HZ

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_PEND_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_PEND_LOW  = 2'd3
    } debounce_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs into i_clk.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            o_q    <= 1'b0;
        end else begin
            meta_q <= i_d;
            o_q    <= meta_q;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button synchroniser + debouncer producing a clean level and press/release pulses.
// Optional long-press pulse enabled by defining BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = button_pkg::DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_PRESS_CYCLES = button_pkg::LONG_PRESS_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw,
    output logic o_sw_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_press
);

    import button_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h00FF_FFFF) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES out of range");
    end
    if (LONG_PRESS_CYCLES < 2) begin : g_bad_long_press
        $error("button_debounce: LONG_PRESS_CYCLES must be at least 2");
    end

    logic             sync_q;
    debounce_state_t  state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_sw),
        .o_q     (sync_q)
    );

    // A pending state accepts the new level only after DEBOUNCE_CYCLES+1 consecutive samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_LOW;
            cnt             <= '0;
            o_sw_level      <= 1'b0;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
        end else begin
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (sync_q) begin
                        state <= ST_PEND_HIGH;
                        cnt   <= '0;
                    end
                end
                ST_PEND_HIGH: begin
                    if (!sync_q) begin
                        state <= ST_LOW;
                    end else if (cnt == CNT_LAST) begin
                        state         <= ST_HIGH;
                        o_sw_level    <= 1'b1;
                        o_press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!sync_q) begin
                        state <= ST_PEND_LOW;
                        cnt   <= '0;
                    end
                end
                ST_PEND_LOW: begin
                    if (sync_q) begin
                        state <= ST_HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state           <= ST_LOW;
                        o_sw_level      <= 1'b0;
                        o_release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_LOW;
            endcase
        end
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned     LP_W    = $clog2(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

    logic [LP_W-1:0] lp_cnt;
    logic            lp_done;
    logic            press_accept;

    always_comb begin
        press_accept = (state == ST_PEND_HIGH) && sync_q && (cnt == CNT_LAST);
    end

    // Hold time keeps accumulating through a rejected release bounce; lp_done limits to one pulse per hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lp_cnt       <= '0;
            lp_done      <= 1'b0;
            o_long_press <= 1'b0;
        end else begin
            o_long_press <= 1'b0;
            if (press_accept) begin
                lp_cnt  <= '0;
                lp_done <= 1'b0;
            end else if ((state == ST_HIGH || state == ST_PEND_LOW) && !lp_done) begin
                if (lp_cnt == LP_LAST) begin
                    o_long_press <= 1'b1;
                    lp_done      <= 1'b1;
                end else begin
                    lp_cnt <= lp_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign o_long_press = 1'b0;
`endif

endmodule
